// File: rtl/ghost_pkg.sv
// ghost_pkg: screen geometry, default sprite size and collision FSM states shared by ghost logic
package ghost_pkg;
    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int OBJ_W_DEF = 64;
    localparam int OBJ_H_DEF = 64;
    typedef enum logic [1:0] {ARMED, FIRED, COOLDOWN} gcd_state_t;
endpackage

// File: rtl/ghost_rect_dr.sv
// ghost_rect_dr: combinational rectangle hit test of a pixel against a sprite's top-left corner
module ghost_rect_dr
    import ghost_pkg::*;
#(
    parameter int OBJ_W = OBJ_W_DEF,
    parameter int OBJ_H = OBJ_H_DEF
) (
    input  logic        valid_i,
    input  logic [31:0] x_i,
    input  logic [31:0] y_i,
    input  logic [10:0] px_i,
    input  logic [10:0] py_i,
    output logic        dr_o
);
    logic [32:0] px, py, x0, y0, x1, y1;
    assign px = {22'd0, px_i};
    assign py = {22'd0, py_i};
    assign x0 = {1'b0, x_i};
    assign y0 = {1'b0, y_i};
    // end bounds carry into bit 32 so sprites near 2^32 never wrap onto the screen
    assign x1 = x0 + 33'(OBJ_W - 1);
    assign y1 = y0 + 33'(OBJ_H - 1);
    assign dr_o = valid_i && px >= x0 && px <= x1 && py >= y0 && py <= y1;
endmodule

// File: rtl/ghost_collision_detector.sv
// ghost_collision_detector: tear-free ghost drawing request and once-per-frame debounced collision pulse
module ghost_collision_detector
    import ghost_pkg::*;
#(
    parameter int OBJ_W           = OBJ_W_DEF,
    parameter int OBJ_H           = OBJ_H_DEF,
    parameter int MIN_OVERLAP     = 4,
    parameter int COOLDOWN_FRAMES = 2
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic [31:0] topLeft_x,
    input  logic [31:0] topLeft_y,
    input  logic        obstacleDR,
    output logic        ghostDR,
    output logic        collision,
    output logic [15:0] hitCount
);
    localparam int OV_W = $clog2(MIN_OVERLAP + 1);
    localparam int CD_W = COOLDOWN_FRAMES > 0 ? $clog2(COOLDOWN_FRAMES + 1) : 1;

    gcd_state_t      state_q, state_d;
    logic [OV_W-1:0] ov_q, ov_d;
    logic [CD_W-1:0] cd_q, cd_d;
    logic [OV_W:0]   sum;
    logic [31:0]     lat_x_q, lat_y_q;
    logic [15:0]     hit_q;
    logic            pos_valid_q, coll_q, fire, dr_new, overlap;

    ghost_rect_dr #(.OBJ_W(OBJ_W), .OBJ_H(OBJ_H)) u_dr (
        .valid_i(pos_valid_q), .x_i(lat_x_q), .y_i(lat_y_q),
        .px_i(pixelX), .py_i(pixelY), .dr_o(ghostDR)
    );

    // on a frame start the pixel belongs to the new frame, so test it against the position being latched
    ghost_rect_dr #(.OBJ_W(OBJ_W), .OBJ_H(OBJ_H)) u_dr_new (
        .valid_i(1'b1), .x_i(topLeft_x), .y_i(topLeft_y),
        .px_i(pixelX), .py_i(pixelY), .dr_o(dr_new)
    );

    assign overlap   = obstacleDR && (startOfFrame ? dr_new : ghostDR);
    assign collision = coll_q;
    assign hitCount  = hit_q;

    // frame bookkeeping first, then count the overlap only if the resulting state is ARMED
    always_comb begin
        state_d = state_q;
        ov_d    = ov_q;
        cd_d    = cd_q;
        sum     = '0;
        fire    = 1'b0;
        if (startOfFrame) begin
            ov_d = '0;
            if (state_q == FIRED) begin
                state_d = COOLDOWN_FRAMES == 0 ? ARMED : COOLDOWN;
                cd_d    = CD_W'(COOLDOWN_FRAMES);
            end else if (state_q == COOLDOWN) begin
                cd_d    = cd_q - CD_W'(1);
                state_d = cd_q == CD_W'(1) ? ARMED : COOLDOWN;
            end
        end
        if (state_d == ARMED) begin
            sum     = {1'b0, ov_d} + (OV_W + 1)'(overlap);
            fire    = sum >= (OV_W + 1)'(MIN_OVERLAP);
            ov_d    = fire ? OV_W'(MIN_OVERLAP) : sum[OV_W-1:0];
            state_d = fire ? FIRED : ARMED;
        end
    end

    // state, counters, position latch and registered outputs
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= ARMED;
            ov_q        <= '0;
            cd_q        <= '0;
            pos_valid_q <= 1'b0;
            lat_x_q     <= '0;
            lat_y_q     <= '0;
            coll_q      <= 1'b0;
            hit_q       <= '0;
        end else begin
            state_q <= state_d;
            ov_q    <= ov_d;
            cd_q    <= cd_d;
            coll_q  <= fire;
            if (fire && hit_q != 16'hFFFF) hit_q <= hit_q + 16'd1;
            if (startOfFrame) begin
                pos_valid_q <= 1'b1;
                lat_x_q     <= topLeft_x;
                lat_y_q     <= topLeft_y;
            end
        end
    end
endmodule

// File: tb/tb_ghost_collision_detector.sv
// tb_ghost_collision_detector: randomized and directed checks of two detector instances against a frame-level model
module tb_ghost_collision_detector;
    localparam int COOL = 2;
    localparam int MINS [2] = '{4, 1};

    logic        clk = 0, resetN = 0, startOfFrame = 0, obstacleDR = 0;
    logic [10:0] pixelX = 0, pixelY = 0;
    logic [31:0] topLeft_x = 0, topLeft_y = 0;
    logic        ghostDR, collision, ghostDR1, collision1;
    logic [15:0] hitCount, hitCount1;

    int vectors = 0, errors = 0;
    int f, live_from [2], cnt [2], hits [2];
    bit pend [2];
    bit mv;
    longint lx, ly;
    logic [35:0] obs_v, exp_v;

    always #5 clk = ~clk;

    ghost_collision_detector dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .pixelX(pixelX), .pixelY(pixelY),
        .topLeft_x(topLeft_x), .topLeft_y(topLeft_y), .obstacleDR(obstacleDR),
        .ghostDR(ghostDR), .collision(collision), .hitCount(hitCount)
    );

    ghost_collision_detector #(.MIN_OVERLAP(1)) dut1 (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .pixelX(pixelX), .pixelY(pixelY),
        .topLeft_x(topLeft_x), .topLeft_y(topLeft_y), .obstacleDR(obstacleDR),
        .ghostDR(ghostDR1), .collision(collision1), .hitCount(hitCount1)
    );

    function automatic bit in_rect(input longint x, input longint y, input int px, input int py);
        return longint'(px) >= x && longint'(px) <= x + 63 && longint'(py) >= y && longint'(py) <= y + 63;
    endfunction

    task automatic model_reset();
        f = -1; mv = 0; lx = 0; ly = 0;
        for (int k = 0; k < 2; k++) begin
            live_from[k] = 0; cnt[k] = 0; hits[k] = 0; pend[k] = 0;
        end
    endtask

    task automatic do_reset();
        resetN = 0; startOfFrame = 0; obstacleDR = 0;
        #2;
        model_reset();
        @(negedge clk);
        resetN = 1;
        @(posedge clk);
        #1;
    endtask

    // one pixel clock: drawing request sampled before the edge, pulse and count after it
    task automatic step(input bit sof, input int px, input int py, input bit ob);
        bit [1:0] odr;
        bit edr;
        startOfFrame = sof; pixelX = 11'(px); pixelY = 11'(py); obstacleDR = ob;
        #1;
        edr = mv && in_rect(lx, ly, px, py);
        odr = {ghostDR, ghostDR1};
        if (sof) begin
            f++; lx = longint'(topLeft_x); ly = longint'(topLeft_y); mv = 1;
            cnt[0] = 0; cnt[1] = 0;
        end
        for (int k = 0; k < 2; k++) begin
            pend[k] = 0;
            if (mv && ob && in_rect(lx, ly, px, py) && f >= live_from[k]) begin
                cnt[k]++;
                if (cnt[k] >= MINS[k]) begin
                    pend[k] = 1;
                    if (hits[k] < 65535) hits[k]++;
                    live_from[k] = f + COOL + 1;
                end
            end
        end
        @(posedge clk);
        #1;
        startOfFrame = 0;
        obs_v = {odr, collision, collision1, hitCount, hitCount1};
        exp_v = {edr, edr, pend[0], pend[1], 16'(hits[0]), 16'(hits[1])};
    endtask

    task automatic test_reset();
        resetN = 0; topLeft_x = 0; topLeft_y = 0; pixelX = 0; pixelY = 0;
        #3;
        vectors++;
        if ({ghostDR, ghostDR1, collision, hitCount} !== 19'd0) begin
            errors++;
            $display("FAIL reset: dr=%b coll=%b hit=%0d required 0", ghostDR, collision, hitCount);
        end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(0, i * 10, i, 1);
            vectors++;
            if (obs_v !== exp_v || ghostDR !== 1'b0) begin
                errors++;
                $display("FAIL pre_sof_dr: got %h required %h", obs_v, exp_v);
            end
        end
    endtask

    task automatic test_basic_hit();
        do_reset();
        topLeft_x = 100; topLeft_y = 200;
        step(1, 0, 0, 0);
        for (int y = 199; y <= 264; y += 13) begin
            for (int x = 98; x <= 166; x++) begin
                step(0, x, y, y == 200 && x >= 100 && x <= 103);
                vectors++;
                if (obs_v !== exp_v) begin
                    errors++;
                    $display("FAIL basic x=%0d y=%0d: got %h required %h", x, y, obs_v, exp_v);
                end
                if (y == 200 && x == 103) begin
                    vectors++;
                    if (collision !== 1'b1 || hitCount !== 16'd1) begin
                        errors++;
                        $display("FAIL basic_pulse: coll=%b hit=%0d required 1/1", collision, hitCount);
                    end
                end
            end
        end
    endtask

    task automatic test_below_threshold();
        do_reset();
        topLeft_x = 100; topLeft_y = 200;
        for (int fr = 0; fr < 5; fr++) begin
            step(1, 0, 0, 0);
            for (int x = 98; x <= 106; x++) begin
                step(0, x, 200, x >= 100 && x <= 102);
                vectors++;
                if (obs_v !== exp_v) begin
                    errors++;
                    $display("FAIL below fr=%0d x=%0d: got %h required %h", fr, x, obs_v, exp_v);
                end
            end
        end
        vectors++;
        if (hitCount !== 16'd0) begin
            errors++;
            $display("FAIL below_hits: got %0d required 0", hitCount);
        end
    endtask

    task automatic test_cooldown();
        int pulses;
        do_reset();
        topLeft_x = 100; topLeft_y = 200;
        for (int fr = 0; fr < 6; fr++) begin
            pulses = 0;
            step(1, 0, 0, 0);
            for (int x = 100; x <= 115; x++) begin
                step(0, x, 200, (x <= 103) || (x >= 110 && x <= 113));
                pulses += int'(collision);
                vectors++;
                if (obs_v !== exp_v) begin
                    errors++;
                    $display("FAIL cooldown fr=%0d x=%0d: got %h required %h", fr, x, obs_v, exp_v);
                end
            end
            vectors++;
            if (pulses !== ((fr == 0 || fr == 3) ? 1 : 0)) begin
                errors++;
                $display("FAIL cooldown_pulses fr=%0d: got %0d", fr, pulses);
            end
        end
        vectors++;
        if (hitCount !== 16'd2) begin
            errors++;
            $display("FAIL cooldown_hits: got %0d required 2", hitCount);
        end
    endtask

    task automatic test_latch();
        do_reset();
        topLeft_x = 100; topLeft_y = 0;
        step(1, 0, 0, 0);
        topLeft_x = 300;
        for (int r = 0; r < 2; r++) begin
            if (r == 1) step(1, 0, 0, 0);
            foreach (MINS[i]) begin
                step(0, i == 0 ? 150 : 310, 10, 0);
                vectors++;
                if (obs_v !== exp_v || ghostDR !== (r == i)) begin
                    errors++;
                    $display("FAIL latch r=%0d i=%0d: got %h required %h", r, i, obs_v, exp_v);
                end
            end
        end
    endtask

    task automatic test_boundary();
        do_reset();
        topLeft_x = 576; topLeft_y = 416;
        step(1, 0, 0, 0);
        step(0, 639, 479, 0);
        vectors++;
        if (obs_v !== exp_v || obs_v[35] !== 1'b1) begin
            errors++;
            $display("FAIL corner: got %h required %h", obs_v, exp_v);
        end
        topLeft_x = 32'hFFFF_FFF0; topLeft_y = 0;
        step(1, 0, 0, 0);
        for (int x = 0; x < 2048; x += 97) begin
            step(0, x, x % 64, 1);
            vectors++;
            if (obs_v !== exp_v || ghostDR !== 1'b0) begin
                errors++;
                $display("FAIL wrap x=%0d: got %h required %h", x, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        topLeft_x = 100; topLeft_y = 200;
        step(1, 0, 0, 0);
        for (int x = 100; x <= 103; x++) step(0, x, 200, 1);
        vectors++;
        if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL reset_mid_pre: got %h required %h", obs_v, exp_v);
        end
        resetN = 0;
        #1;
        vectors++;
        if (collision !== 1'b0 || hitCount !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid: coll=%b hit=%0d required 0/0", collision, hitCount);
        end
        do_reset();
        topLeft_x = 100; topLeft_y = 200;
        step(1, 100, 200, 1);
        vectors++;
        if (obs_v !== exp_v || collision1 !== 1'b1 || collision !== 1'b0) begin
            errors++;
            $display("FAIL sof_overlap: got %h required %h", obs_v, exp_v);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int fr = 0; fr < 30; fr++) begin
            topLeft_x = $urandom_range(0, 40); topLeft_y = $urandom_range(0, 3);
            step(1, $urandom_range(0, 100), $urandom_range(0, 70), 1'($urandom_range(0, 1)));
            for (int i = 0; i < 15; i++) begin
                if ($urandom_range(0, 9) == 0) topLeft_x = $urandom_range(0, 200);
                step(0, $urandom_range(0, 100), $urandom_range(0, 70), 1'($urandom_range(0, 1)));
                vectors++;
                if (obs_v !== exp_v) begin
                    errors++;
                    $display("FAIL random fr=%0d i=%0d: got %h required %h", fr, i, obs_v, exp_v);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_hit();
        test_below_threshold();
        test_cooldown();
        test_latch();
        test_boundary();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/ghost_collision_detector.md
# ghost_collision_detector

Consumes the ghost position produced by the ghost mover (`topLeft_x`/`topLeft_y`) and the VGA pixel stream. Generates the ghost's drawing request and the single-cycle `collision` pulse that the mover consumes to reverse direction. Sits between the ghost mover, the obstacle drawing logic and the VGA controller. Guarantees at most one collision per frame, followed by a frame-based cooldown, so the mover never sees repeated reversals from one contact.

## Interface
- `OBJ_W`, 64: ghost width in pixels.
- `OBJ_H`, 64: ghost height in pixels.
- `MIN_OVERLAP`, 4: overlapping pixels per frame needed to fire; must be ≥1.
- `COOLDOWN_FRAMES`, 2: whole frames ignored after a firing frame; 0 allowed.
- `clk`  in  1  pixel clock.
- `resetN`  in  1  reset, asynchronous, active-low.
- `startOfFrame`  in  1  one-cycle pulse at the first pixel of each frame.
- `pixelX`  in  11  current pixel column.
- `pixelY`  in  11  current pixel row.
- `topLeft_x`  in  32  ghost top-left X from the mover, unsigned.
- `topLeft_y`  in  32  ghost top-left Y from the mover, unsigned.
- `obstacleDR`  in  1  obstacle drawing request, aligned with `pixelX`/`pixelY`.
- `ghostDR`  out  1  ghost covers the current pixel.
- `collision`  out  1  one-cycle pulse to the mover.
- `hitCount`  out  16  total collisions since reset; saturates at 16'hFFFF.

## Operation
- **Position latch**
  - `topLeft_x`/`topLeft_y` are latched on every `startOfFrame` cycle.
  - `ghostDR` uses only the latched values, so mid-frame moves never tear the image.
  - A `posValid` flag is cleared by reset and set on the first `startOfFrame`. `ghostDR` is 0 while `posValid` is 0.
- **Ghost drawing request**
  - `ghostDR` = `posValid` && `latX` ≤ `pixelX` ≤ `latX+OBJ_W-1` && `latY` ≤ `pixelY` ≤ `latY+OBJ_H-1`.
  - Comparisons are unsigned. Pixels are zero-extended to 33 bits and the end bounds are computed in 33 bits, so positions near 2^32 never wrap.
  - Positions ≥ 640/480 simply never match.
- **Overlap counting**
  - `overlap` = `ghostDR && obstacleDR`.
  - `ovCnt` (width ≥ clog2(MIN_OVERLAP+1)) increments per overlap cycle while in ARMED and saturates at MIN_OVERLAP.
- **States**
  - ARMED → FIRED when `ovCnt+overlap` reaches MIN_OVERLAP. The same transition pulses `collision` and increments `hitCount`.
  - FIRED → on `startOfFrame`: to COOLDOWN with `cdCnt`=COOLDOWN_FRAMES, or straight to ARMED if COOLDOWN_FRAMES=0. Clears `ovCnt`.
  - COOLDOWN → on each `startOfFrame`, decrement `cdCnt`. When it reaches 0 go to ARMED; that frame is live. Overlaps are ignored in COOLDOWN.
  - ARMED on `startOfFrame`: clear `ovCnt`.
- **Simultaneous events**
  - An overlap on a `startOfFrame` cycle counts as the first pixel of the new frame: `ovCnt` becomes 1, and the pulse fires if MIN_OVERLAP=1.
  - It counts only if the state after that edge is ARMED. It is evaluated against the positions latched on that same edge, i.e. the new frame's.
- **Reset mid-frame**: all state clears immediately. `collision` drops the same instant and no pulse is emitted until after the next `startOfFrame`.

## Timing
- `ghostDR`: combinational from latched position and current pixel; zero latency.
- `collision`: registered. High for exactly the one cycle after the clock edge that samples the threshold-reaching overlap.
- `hitCount`: updates on the same edge that raises `collision`.
- At most one `collision` per frame. With COOLDOWN_FRAMES=N, the minimum spacing between pulses is N+1 frames.
- Reset values:
  - `collision`=0, `hitCount`=0, `ghostDR`=0.
  - state=ARMED, `ovCnt`=0, `cdCnt`=0, `posValid`=0, latched position=0.

## Structure
- Shared package `ghost_pkg`: screen constants (640, 480), default `OBJ_W`/`OBJ_H`, and the state enum `gcd_state_t` {ARMED, FIRED, COOLDOWN}. The ghost mover uses the same size constants for its borders.
- One natural sub-module, `ghost_rect_dr`: the combinational rectangle hit test (latched pos, pixel → `ghostDR`). It is reusable for other sprites.
- Position latch, counters and FSM live in the top module.

## Test plan
- **Basic hit.** Reset, then SOF with pos (100,200). Drive `obstacleDR`=1 for pixels x=100..103 on y=200.
  - `ghostDR`=1 exactly at x∈[100,163] on y∈[200,263].
  - One `collision` pulse the cycle after x=103; `hitCount`=1.
- **Below threshold.** Only 3 overlapping pixels per frame for 5 frames → no `collision`, `hitCount`=0.
- **Cooldown (COOLDOWN_FRAMES=2).** Overlap ≥4 px in every frame for frames 0–5.
  - Pulses in frames 0 and 3 only; `hitCount`=2 after frame 5.
  - Second overlap run within frame 0 produces no extra pulse.
- **Tear-free latch.** `topLeft_x` changes 100→300 mid-frame.
  - `ghostDR` keeps using 100 until the next SOF, then 300.
  - Before the first SOF after reset, `ghostDR`=0 everywhere.
- **Boundary and wrap.** pos (576,416) → `ghostDR` at pixel (639,479). pos (32'hFFFFFFF0,0) → `ghostDR` never asserts.
- **Reset mid-operation / SOF coincidence.**
  - Assert `resetN`=0 the cycle `collision` is high → drops immediately; `hitCount`=0.
  - With MIN_OVERLAP=1 and overlap on the SOF cycle of a live frame → pulse on the next cycle.
